pio_avmm_responder: RTL and testbench
=====================================

Name: pio_avmm_responder

Overview:
- Fabric-side Avalon-MM responder for the HPS lightweight bridge.
- Samples the board button and DIP switches, debounces them and captures edges.
- Raises a maskable interrupt to the HPS and drives the LED register.
- Sits between the HPS lightweight-bridge master and the board I/O. It takes over the button, dipsw and led PIO roles from the fabric side.

Parameters:
- IN_W, 5, number of input bits: bit0 = button, bits 4:1 = dipsw.
- LED_W, 8, width of the LED output register.
- DEB_CYCLES, 50000, consecutive stable cycles required before a debounced bit changes (1 ms at 50 MHz).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- avs_readdatavalid  out  1  read data valid.
- pio_in  in  IN_W  raw asynchronous board inputs.
- led_out  out  LED_W  LED drive.
- irq  out  1  level interrupt to the HPS.

Behaviour:
- Interface: one clock (clk_clk); reset (reset_reset) is synchronous and active-high.
- Reset values:
  - avs_readdata = 0, avs_readdatavalid = 0, led_out = 0, irq = 0.
  - Debounced state = 0, sync flops = 0, counters = 0, mask = 0, edge = 0.
- Input path, per bit:
  - 2-FF synchroniser.
  - Debounce counter clears whenever the sync value equals the stable value.
  - Otherwise the counter increments. On reaching DEB_CYCLES-1 the stable bit takes the sync value and the counter clears.
  - A glitch shorter than DEB_CYCLES never changes the stable bit.
  - Latency raw-to-stable = 2 + DEB_CYCLES cycles.
- Register map, word addressed; unused bits read 0:
  - 0 DATA: RO, stable[IN_W-1:0].
  - 1 LED: RW, writedata[LED_W-1:0] to led_out on the cycle after the write.
  - 2 MASK: RW, irq enable per input bit.
  - 3 EDGE: RW1C, sticky any-edge capture per bit.
  - 4-7: read 0, writes ignored.
- Read timing:
  - Fixed latency 1: avs_readdatavalid pulses exactly one cycle after avs_read.
  - avs_readdata is held until the next read.
  - No waitrequest; back-to-back reads every cycle are supported.
- Edge capture:
  - edge[i] sets on the cycle the stable bit i changes, in either direction.
  - A write to EDGE with bit i = 1 clears edge[i].
  - Same cycle set and clear: set wins.
- irq is registered: irq = |(edge & mask), one cycle after the edge or mask update.
- Simultaneous read and write in one cycle:
  - Both are performed.
  - Read returns the pre-write value.
- Reset mid-read: the pending readdatavalid is suppressed.

Optional Feature:
- Macro PIO_AVMM_IRQ_EN.
- Defined: MASK and EDGE registers and irq logic are present as above.
- Undefined:
  - MASK/EDGE logic is removed.
  - Addresses 2 and 3 read 0 and ignore writes.
  - irq is tied 0.
  - The debounce and DATA/LED paths are unchanged.

Decomposition:
- Shared package pio_avmm_pkg holds:
  - Register address constants ADDR_DATA=0, ADDR_LED=1, ADDR_MASK=2, ADDR_EDGE=3.
  - The data width constant 32.
- One sub-module: pio_debounce (single bit: synchroniser, counter, stable output, change pulse), instantiated IN_W times.

Test Plan:
- Reset, then read each of addresses 0-7 -> readdatavalid one cycle after each read; all data 0; led_out = 0; irq = 0.
- Write LED = 0xA5 -> led_out = 0xA5 the next cycle; a read of address 1 returns 0x000000A5. Write 0x1FF -> led_out = 0xFF.
- DEB_CYCLES=8: pulse pio_in[0] high for 5 cycles -> DATA stays 0, EDGE stays 0. Hold high for 12 cycles -> DATA = 0x1 exactly 10 cycles after the rise, and EDGE bit0 = 1.
- MASK = 0x01, then a button edge -> irq = 1 one cycle after the edge bit sets. Write EDGE = 0x01 -> irq = 0 the next cycle. MASK = 0 with edge pending -> irq = 0.
- Write EDGE = 0x01 in the same cycle the stable bit0 changes -> edge bit0 remains 1.
- Assert reset during a read -> no readdatavalid. With PIO_AVMM_IRQ_EN undefined, reads of addresses 2 and 3 return 0 and irq never asserts.

Source files
------------

// File: rtl/pio_avmm_pkg.sv
// Shared constants and types for the PIO Avalon-MM responder.
package pio_avmm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_LED  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(3);

  // One Avalon-MM slave request as seen in a single cycle.
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } avs_req_t;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: 2-FF synchroniser, stability counter,
// debounced output and a one-cycle change indication.
module pio_debounce #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic change_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // High in the cycle whose clock edge flips the stable bit.
  assign change_c = (sync2 != stable) && (cnt == CNT_LAST);

  // Synchronise, then accept a new level only after it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_avmm_responder.sv
// Avalon-MM responder for the HPS lightweight bridge: debounced button/dipsw
// inputs, LED register and optional edge-capture interrupt.
// Optional feature macro: PIO_AVMM_IRQ_EN (MASK/EDGE registers and irq).
module pio_avmm_responder
  import pio_avmm_pkg::*;
#(
  parameter int unsigned IN_W       = 5,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [IN_W-1:0]   pio_in,
  output logic [LED_W-1:0]  led_out,
  output logic              irq
);

  avs_req_t          req;
  logic [IN_W-1:0]   stable;
  logic [IN_W-1:0]   change_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              unused_sink;

  assign req = '{read: avs_read, write: avs_write, addr: avs_address, wdata: avs_writedata};

  // Upper write-data bits (and change pulses in the reduced build) have no sink.
  assign unused_sink = ^{avs_writedata, change_c};

  // One conditioner per input bit.
  for (genvar i = 0; i < int'(IN_W); i++) begin : g_deb
    pio_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .raw      (pio_in[i]),
      .stable   (stable[i]),
      .change_c (change_c[i])
    );
  end

`ifdef PIO_AVMM_IRQ_EN
  logic [IN_W-1:0] mask_q;
  logic [IN_W-1:0] edge_q;
  logic [IN_W-1:0] edge_n_c;
  logic            mask_wr_c;
  logic            edge_wr_c;

  assign mask_wr_c = req.write && (req.addr == ADDR_MASK);
  assign edge_wr_c = req.write && (req.addr == ADDR_EDGE);

  // Write-one-to-clear, with a same-cycle capture taking priority.
  always_comb begin
    edge_n_c = edge_q;
    if (edge_wr_c) begin
      edge_n_c = edge_q & ~IN_W'(req.wdata);
    end
    edge_n_c = edge_n_c | change_c;
  end

  // Mask, sticky edge capture and registered interrupt level.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mask_q <= '0;
      edge_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (mask_wr_c) begin
        mask_q <= IN_W'(req.wdata);
      end
      edge_q <= edge_n_c;
      irq    <= |(edge_q & mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux over the pre-write register contents.
  always_comb begin
    rd_data_c = '0;
    case (req.addr)
      ADDR_DATA: rd_data_c = DATA_W'(stable);
      ADDR_LED:  rd_data_c = DATA_W'(led_out);
`ifdef PIO_AVMM_IRQ_EN
      ADDR_MASK: rd_data_c = DATA_W'(mask_q);
      ADDR_EDGE: rd_data_c = DATA_W'(edge_q);
`endif
      default:   rd_data_c = '0;
    endcase
  end

  // Fixed-latency read response and LED register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      led_out           <= '0;
    end else begin
      avs_readdatavalid <= req.read;
      if (req.read) begin
        avs_readdata <= rd_data_c;
      end
      if (req.write && (req.addr == ADDR_LED)) begin
        led_out <= LED_W'(req.wdata);
      end
    end
  end

endmodule

// File: tb/tb_pio_avmm_responder.sv
// Self-checking bench for pio_avmm_responder with a short debounce window.
module tb_pio_avmm_responder;

  localparam int unsigned IN_W  = 5;
  localparam int unsigned LED_W = 8;
  localparam int unsigned DEB   = 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic [2:0]        avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [IN_W-1:0]   pio_in;
  logic [LED_W-1:0]  led_out;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PIO_AVMM_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  pio_avmm_responder #(
    .IN_W(IN_W), .LED_W(LED_W), .DEB_CYCLES(DEB), .CNT_W(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .pio_in(pio_in),
    .led_out(led_out), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  // Reference model state.
  logic [IN_W-1:0]  m_stable, m_edge, m_mask;
  logic [LED_W-1:0] m_led;
  logic             m_irq, m_rdv;
  logic [31:0]      m_rd;
  logic [IN_W-1:0]  hist[$];

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0: return {27'b0, m_stable};
      3'd1: return {24'b0, m_led};
      3'd2: return IRQ_EN ? {27'b0, m_mask} : 32'h0;
      3'd3: return IRQ_EN ? {27'b0, m_edge} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // A bit flips once its synchronised (2-cycle delayed) raw value has
  // disagreed with the debounced value for DEB consecutive cycles.
  always @(posedge clk_clk) begin : model
    logic [IN_W-1:0] chg;
    logic            agree;
    int              idx;
    logic            v;
    if (reset_reset) begin
      m_stable = '0; m_edge = '0; m_mask = '0; m_led = '0;
      m_irq = 1'b0; m_rdv = 1'b0; m_rd = '0;
      hist.delete();
    end else begin
      m_rdv = avs_read;
      if (avs_read) m_rd = m_reg(avs_address);
      hist.push_back(pio_in);
      if (hist.size() > 40) void'(hist.pop_front());
      chg = '0;
      for (int b = 0; b < int'(IN_W); b++) begin
        agree = 1'b1;
        for (int j = 0; j < int'(DEB); j++) begin
          idx = int'(hist.size()) - 3 - j;
          v = (idx >= 0) ? hist[idx][b] : 1'b0;
          if (v == m_stable[b]) agree = 1'b0;
        end
        chg[b] = agree;
      end
      m_irq = IRQ_EN && (|(m_edge & m_mask));
      if (IRQ_EN) begin
        if (avs_write && avs_address == 3'd3) m_edge = m_edge & ~avs_writedata[IN_W-1:0];
        m_edge = m_edge | chg;
        if (avs_write && avs_address == 3'd2) m_mask = avs_writedata[IN_W-1:0];
      end
      if (avs_write && avs_address == 3'd1) m_led = avs_writedata[LED_W-1:0];
      m_stable = m_stable ^ chg;
    end
  end

  // Apply one cycle of bus stimulus and return at the following negedge.
  task automatic cyc(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset_reset = 1'b0;
    n_tests++;
    if (led_out !== 8'h00 || irq !== 1'b0 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: led=%h irq=%b rdv=%b rd=%h, required 00/0/0/0", led_out, irq, avs_readdatavalid, avs_readdata);
    end
    for (int a = 0; a < 8; a++) begin
      cyc(1, 0, 3'(a), 0);
      n_tests++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read a=%0d: rdv=%b rd=%h, required 1/00000000", a, avs_readdatavalid, avs_readdata);
      end
    end
    cyc(0, 0, 0, 0);
    n_tests++;
    if (avs_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdv_single_pulse: rdv=%b, required 0", avs_readdatavalid);
    end
  endtask

  task automatic test_led();
    cyc(0, 1, 1, 32'hA5);
    n_tests++;
    if (led_out !== 8'hA5) begin n_fail++; $display("FAIL led_write: led=%h, required a5", led_out); end
    cyc(1, 0, 1, 0);
    n_tests++;
    if (avs_readdata !== 32'h000000A5) begin n_fail++; $display("FAIL led_read: rd=%h, required 000000a5", avs_readdata); end
    cyc(0, 1, 1, 32'h1FF);
    n_tests++;
    if (led_out !== 8'hFF) begin n_fail++; $display("FAIL led_trunc: led=%h, required ff", led_out); end
    for (int k = 0; k < 8; k++) begin
      logic rd;
      rd = 1'($urandom_range(0, 1));
      cyc(rd, 1, 1, $urandom);
      n_tests++;
      if (led_out !== m_led || avs_readdata !== m_rd || avs_readdatavalid !== m_rdv) begin
        n_fail++;
        $display("FAIL led_rw_same_cycle k=%0d: led=%h rd=%h rdv=%b, required %h/%h/%b", k, led_out, avs_readdata, avs_readdatavalid, m_led, m_rd, m_rdv);
      end
    end
  endtask

  task automatic test_debounce();
    pio_in[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      n_tests++;
      if (avs_readdata !== 32'h0 || avs_readdata !== m_rd) begin
        n_fail++; $display("FAIL glitch_data i=%0d: rd=%h, required 0 (model %h)", i, avs_readdata, m_rd);
      end
    end
    pio_in[0] = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
    n_tests++;
    if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL glitch_settle: rd=%h, required 0", avs_readdata); end
    cyc(1, 0, 3, 0);
    n_tests++;
    if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: rd=%h, required 0", avs_readdata); end
    pio_in[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 0, 0, 0);
      n_tests++;
      if (avs_readdata !== ((i >= 11) ? 32'h1 : 32'h0) || avs_readdata !== m_rd) begin
        n_fail++; $display("FAIL rise_latency i=%0d: rd=%h, required %h", i, avs_readdata, (i >= 11) ? 32'h1 : 32'h0);
      end
    end
    cyc(1, 0, 3, 0);
    n_tests++;
    if (avs_readdata !== (IRQ_EN ? 32'h1 : 32'h0)) begin
      n_fail++; $display("FAIL rise_edge: rd=%h, required %h", avs_readdata, IRQ_EN ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) pio_in[4:1] = 4'($urandom);
      cyc(1, 0, 0, 0);
      n_tests++;
      if (avs_readdata !== m_rd) begin n_fail++; $display("FAIL dipsw_random i=%0d: rd=%h, required %h", i, avs_readdata, m_rd); end
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_tests++;
    if (avs_readdata !== {27'b0, pio_in}) begin n_fail++; $display("FAIL dipsw_settle: rd=%h, required %h", avs_readdata, {27'b0, pio_in}); end
  endtask

  task automatic test_irq();
    cyc(0, 1, 3, 32'h1F);
    cyc(0, 1, 2, 32'h01);
    cyc(0, 0, 0, 0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: irq=%b, required 0", irq); end
    pio_in[0] = ~pio_in[0];
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 0, 0);
      n_tests++;
      if (irq !== m_irq) begin n_fail++; $display("FAIL irq_track i=%0d: irq=%b, required %b", i, irq, m_irq); end
    end
    n_tests++;
    if (irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_raise: irq=%b, required %b", irq, IRQ_EN); end
    cyc(0, 1, 3, 32'h01);
    cyc(0, 0, 0, 0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b, required 0", irq); end
    pio_in[0] = ~pio_in[0];
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 2, 32'h0);
    cyc(1, 0, 3, 0);
    n_tests++;
    if (irq !== 1'b0 || avs_readdata !== (IRQ_EN ? 32'h1 : 32'h0)) begin
      n_fail++; $display("FAIL irq_masked: irq=%b edge=%h, required 0/%h", irq, avs_readdata, IRQ_EN ? 32'h1 : 32'h0);
    end
    cyc(1, 0, 2, 0);
    n_tests++;
    if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL mask_read: rd=%h, required 0", avs_readdata); end
  endtask

  task automatic test_set_wins();
    cyc(0, 1, 3, 32'h1F);
    pio_in[0] = ~pio_in[0];
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 3, 32'h01);
    cyc(1, 0, 3, 0);
    n_tests++;
    if (avs_readdata !== (IRQ_EN ? 32'h1 : 32'h0) || avs_readdata !== m_rd) begin
      n_fail++; $display("FAIL set_wins: edge=%h, required %h", avs_readdata, IRQ_EN ? 32'h1 : 32'h0);
    end
  endtask

  task automatic test_reset_mid_read();
    cyc(0, 1, 1, 32'h3C);
    reset_reset = 1'b1;
    cyc(1, 0, 1, 0);
    n_tests++;
    if (avs_readdatavalid !== 1'b0 || led_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_read: rdv=%b led=%h, required 0/00", avs_readdatavalid, led_out);
    end
    reset_reset = 1'b0;
    cyc(0, 0, 0, 0);
    n_tests++;
    if (avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_no_late_rdv: rdv=%b, required 0", avs_readdatavalid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) pio_in = 5'($urandom);
      cyc(rd, wr, 3'($urandom_range(0, 7)), $urandom);
      n_tests++;
      if (avs_readdatavalid !== m_rdv || avs_readdata !== m_rd || led_out !== m_led || irq !== m_irq) begin
        n_fail++;
        $display("FAIL b2b i=%0d: rdv=%b rd=%h led=%h irq=%b, required %b/%h/%h/%b", i, avs_readdatavalid, avs_readdata, led_out, irq, m_rdv, m_rd, m_led, m_irq);
      end
    end
  endtask

  initial begin
    reset_reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; pio_in = '0;
    @(negedge clk_clk);
    test_reset();
    test_led();
    test_debounce();
    test_irq();
    test_set_wins();
    test_reset_mid_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
